// File: rtl/syscall_unit.sv
// syscall_unit: services decode-stage syscalls (print_int, print_char, exit); optional print_hex via SYSCALL_HEX_EN
module syscall_unit #(
  parameter bit SUPPRESS_ZEROS    = 1'b1,
  parameter bit NEWLINE_AFTER_INT = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        syscall,
  input  logic [31:0] syscall_funct,
  input  logic [31:0] syscall_param1,
  output logic        stall,
  output logic        out_valid,
  output logic [7:0]  out_byte,
  input  logic        out_ready,
  output logic        halted,
  output logic [7:0]  exit_code,
  output logic        bad_syscall
);
  typedef enum logic [2:0] {IDLE, CONVERT, EMIT_SIGN, EMIT_DIGITS, EMIT_NL, EMIT_CHAR, DONE, HALT} state_t;
  state_t state, state_n;
  logic [31:0] bin;
  logic [39:0] bcd, dab, bcd_cv;
  logic [4:0]  cnt;
  logic [3:0]  idx, lz, nib;
  logic [7:0]  chr, dch;
  logic        neg, hex;
  logic        f_int, f_chr, f_exit, f_exit2, f_hex, supported, accept, xfer;
  assign f_int  = syscall_funct == 32'd1;
  assign f_chr  = syscall_funct == 32'd11;
  assign f_exit = syscall_funct == 32'd10;
  assign f_exit2 = syscall_funct == 32'd17;
`ifdef SYSCALL_HEX_EN
  assign f_hex = syscall_funct == 32'd34;
`else
  assign f_hex = 1'b0;
`endif
  assign supported   = f_int | f_chr | f_exit | f_exit2 | f_hex;
  assign accept      = syscall & (state == IDLE);
  assign stall       = !(state inside {IDLE, DONE}) | (accept & supported);
  assign bad_syscall = accept & !supported;
  assign halted      = state == HALT;
  assign out_valid   = state inside {EMIT_SIGN, EMIT_DIGITS, EMIT_NL, EMIT_CHAR};
  assign xfer        = out_valid & out_ready;
  // Hex mode stores digits as {8'h00, value}: index 0 yields '0' and index 1 is replaced by 'x'
  assign nib = bcd[{4'd9 - idx, 2'b00} +: 4];
  assign dch = (hex && idx == 4'd1) ? 8'h78 : (nib < 4'd10) ? {4'h3, nib} : 8'h57 + {4'h0, nib};
  assign out_byte = state == EMIT_SIGN   ? 8'h2D :
                    state == EMIT_DIGITS ? dch :
                    state == EMIT_NL     ? 8'h0A :
                    state == EMIT_CHAR   ? chr : 8'h00;
  // One double-dabble step: add 3 to every digit >= 5, then shift in the next binary bit
  always_comb begin
    dab = bcd;
    for (int i = 0; i < 10; i++)
      dab[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    bcd_cv = {dab[38:0], bin[31]};
  end
  // Leading zero digits of the final BCD, capped so the units digit is always printed
  always_comb begin
    lz = 4'd9;
    for (int j = 8; j >= 0; j--)
      if (bcd_cv[(9 - j)*4 +: 4] != 4'd0) lz = 4'(j);
  end
  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:        if (accept) state_n = f_int ? CONVERT : f_chr ? EMIT_CHAR : (f_exit | f_exit2) ? HALT : f_hex ? EMIT_DIGITS : DONE;
      CONVERT:     if (cnt == 5'd31) state_n = neg ? EMIT_SIGN : EMIT_DIGITS;
      EMIT_SIGN:   if (xfer) state_n = EMIT_DIGITS;
      EMIT_DIGITS: if (xfer && idx == 4'd9) state_n = NEWLINE_AFTER_INT ? EMIT_NL : DONE;
      EMIT_NL:     if (xfer) state_n = DONE;
      EMIT_CHAR:   if (xfer) state_n = DONE;
      DONE:        state_n = IDLE;
      default:     state_n = HALT;
    endcase
  end
  // State register and datapath: latch arguments on accept, shift during CONVERT, advance digit on transfer
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      exit_code <= 8'h00;
      bin       <= 32'd0;
      bcd       <= 40'd0;
      cnt       <= 5'd0;
      idx       <= 4'd0;
      chr       <= 8'h00;
      neg       <= 1'b0;
      hex       <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        neg <= syscall_param1[31];
        bin <= syscall_param1[31] ? -syscall_param1 : syscall_param1;
        bcd <= f_hex ? {8'h00, syscall_param1} : 40'd0;
        hex <= f_hex;
        cnt <= 5'd0;
        idx <= 4'd0;
        chr <= syscall_param1[7:0];
        if (f_exit) exit_code <= 8'h00;
        if (f_exit2) exit_code <= syscall_param1[7:0];
      end
      if (state == CONVERT) begin
        bcd <= bcd_cv;
        bin <= bin << 1;
        cnt <= cnt + 5'd1;
        if (cnt == 5'd31 && SUPPRESS_ZEROS) idx <= lz;
      end
      if (state == EMIT_DIGITS && xfer) idx <= idx + 4'd1;
    end
  end
endmodule

// File: tb/tb_syscall_unit.sv
// tb_syscall_unit: table-driven check of syscall_unit with default parameters
module tb_syscall_unit;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        syscall = 1'b0;
  logic [31:0] syscall_funct = 32'd0;
  logic [31:0] syscall_param1 = 32'd0;
  logic        stall, out_valid, out_ready, halted, bad_syscall;
  logic [7:0]  out_byte, exit_code;
  int total = 0;
  int bad = 0;

  syscall_unit dut (
    .clock(clock), .reset(reset), .syscall(syscall), .syscall_funct(syscall_funct),
    .syscall_param1(syscall_param1), .stall(stall), .out_valid(out_valid), .out_byte(out_byte),
    .out_ready(out_ready), .halted(halted), .exit_code(exit_code), .bad_syscall(bad_syscall)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] funct;
    logic [31:0] param;
    bit          tog;
    int          len;
    logic [87:0] s;
    int          exp_stall;
  } vec_t;
  vec_t vecs[9];

  task automatic check(input string name, input logic [87:0] act, input logic [87:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Issue one syscall at a negedge, hold it until stall drops (DONE), collect transferred bytes
  task automatic run_call(input vec_t v);
    logic [87:0] cap = '0;
    logic [7:0]  held = 8'h00;
    bit          waiting = 1'b0;
    int          n = 0;
    int          sc = 0;
    syscall = 1'b1;
    syscall_funct = v.funct;
    syscall_param1 = v.param;
    out_ready = 1'b1;
    for (int c = 0; c < 300; c++) begin
      #1;
      if (!stall) break;
      sc++;
      if (waiting && out_valid) check("hold_byte", {80'd0, out_byte}, {80'd0, held});
      waiting = out_valid && !out_ready;
      held = out_byte;
      if (out_valid && out_ready) begin
        cap = {cap[79:0], out_byte};
        n++;
      end
      @(negedge clock);
      if (v.tog) out_ready = ~out_ready;
    end
    check("timeout", {87'd0, stall}, 88'd0);
    if (!v.tog) check("stall_cycles", 88'(sc), 88'(v.exp_stall));
    check("bytes", cap, v.s);
    check("byte_count", 88'(n), 88'(v.len));
    check("done_valid", {87'd0, out_valid}, 88'd0);
    @(negedge clock);
    syscall = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    vecs[0] = '{32'd1,  32'd0,          1'b0, 1,  "0",           34};
    vecs[1] = '{32'd1,  32'h8000_0000,  1'b0, 11, "-2147483648", 44};
    vecs[2] = '{32'd1,  32'd305,        1'b1, 3,  "305",         0};
    vecs[3] = '{32'd1,  32'hFFFF_FFF9,  1'b0, 2,  "-7",          35};
    vecs[4] = '{32'd1,  32'd2147483647, 1'b0, 10, "2147483647",  43};
    vecs[5] = '{32'd1,  32'd1000000000, 1'b0, 10, "1000000000",  43};
    vecs[6] = '{32'd11, 32'h1234_5641,  1'b0, 1,  "A",           2};
    vecs[7] = '{32'd11, 32'h1234_5641,  1'b0, 1,  "A",           2};
    vecs[8] = '{32'd11, 32'h0000_000A,  1'b0, 1,  88'h0A,        2};
    out_ready = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    check("rst_out", {75'd0, stall, out_valid, out_byte, halted, bad_syscall}, 88'd0);
    check("rst_exit", {80'd0, exit_code}, 88'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 9; i++) run_call(vecs[i]);
    // Unsupported funct: single bad_syscall pulse, never stalls
    syscall = 1'b1;
    syscall_funct = 32'd99;
    #1;
    check("bad_pulse", {86'd0, bad_syscall, stall}, 88'd2);
    @(negedge clock);
    #1;
    check("bad_after", {86'd0, bad_syscall, stall}, 88'd0);
    @(negedge clock);
    syscall = 1'b0;
`ifdef SYSCALL_HEX_EN
    @(negedge clock);
    run_call('{32'd34, 32'hDEAD_BEEF, 1'b0, 10, "0xdeadbeef", 11});
`else
    @(negedge clock);
    syscall = 1'b1;
    syscall_funct = 32'd34;
    #1;
    check("hex_off", {86'd0, bad_syscall, stall}, 88'd2);
    @(negedge clock);
    syscall = 1'b0;
`endif
    // Reset while a digit is waiting on the console aborts it
    @(negedge clock);
    out_ready = 1'b0;
    syscall = 1'b1;
    syscall_funct = 32'd1;
    syscall_param1 = 32'd5;
    repeat (36) @(negedge clock);
    #1;
    check("wait_byte", {79'd0, out_valid, out_byte}, {79'd0, 1'b1, 8'h35});
    @(negedge clock);
    reset = 1'b1;
    syscall = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("abort", {86'd0, out_valid, stall}, 88'd0);
    out_ready = 1'b1;
    // exit: exit_code 0, halt
    @(negedge clock);
    syscall = 1'b1;
    syscall_funct = 32'd10;
    syscall_param1 = 32'hFF;
    #1;
    check("exit_stall", {87'd0, stall}, 88'd1);
    @(negedge clock);
    syscall = 1'b0;
    #1;
    check("exit_halt", {78'd0, halted, stall, exit_code}, {78'd0, 2'b11, 8'h00});
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    // exit2: exit_code from param1, halted until reset
    syscall = 1'b1;
    syscall_funct = 32'd17;
    syscall_param1 = 32'h0000_012A;
    @(negedge clock);
    syscall = 1'b0;
    #1;
    check("exit2_halt", {77'd0, halted, stall, out_valid, exit_code}, {77'd0, 3'b110, 8'h2A});
    repeat (3) @(negedge clock);
    #1;
    check("exit2_hold", {77'd0, halted, stall, out_valid, exit_code}, {77'd0, 3'b110, 8'h2A});
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("post_rst", {74'd0, stall, out_valid, out_byte, halted, exit_code, bad_syscall}, 88'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
